core_mem_arbiter: RTL and testbench
===================================

// Module: core_mem_arbiter
// PURPOSE
//  Sits directly downstream of the arm810 core: merges its instruction-fetch port (multi-word reads) and
//  data port (single-word read/write with byte enables) onto one 32-bit memory master with waitrequest.
//  Holds pending requests, sequences multi-beat fetches, returns 1-cycle ready pulses to the core.
// PARAMETERS
//  INSN_WORDS  2   32-bit beats per instruction fetch (power of 2, 1..4); insn_data_rd is 32*INSN_WORDS wide
// PORTS
//  clk              in   1        core clock; all logic on rising edge
//  rst              in   1        asynchronous, active-high reset
//  insn_start       in   1        1-cycle pulse: fetch request, address captured this cycle
//  insn_addr        in   30-log2(INSN_WORDS)  fetch-unit-aligned address (byte addr >> (2+log2 INSN_WORDS))
//  insn_ready       out  1        1-cycle pulse: insn_data_rd valid
//  insn_data_rd     out  32*INSN_WORDS  fetched data, beat 0 in bits [31:0]; held until next insn_ready
//  data_start       in   1        1-cycle pulse: data request; addr/write/be/wr captured this cycle
//  data_addr        in   30       word address
//  data_write       in   1        1=write, 0=read
//  data_data_be     in   4        byte enables (writes; reads drive 4'hF)
//  data_data_wr     in   32       write data
//  data_ready       out  1        1-cycle pulse: data access complete
//  data_data_rd     out  32       read data; held until next data_ready of a read
//  avl_address      out  30       memory word address
//  avl_read         out  1        read strobe
//  avl_write        out  1        write strobe
//  avl_writedata    out  32       write data
//  avl_byteenable   out  4        byte enables
//  avl_readdata     in   32       read data, valid in the cycle avl_read=1 and avl_waitrequest=0
//  avl_waitrequest  in   1        1=hold current command unchanged
// BEHAVIOUR
//  Reset: FSM=IDLE, both pending flags clear; all outputs 0 (insn_data_rd, data_data_rd cleared to 0).
//  Capture: start pulse sets port's pending flag and latches its request fields; start while that port
//   is already pending/in flight is ignored (protocol violation; sim assertion fires).
//  FSM: IDLE -> DATA if data pending, else -> INSN if insn pending (decision uses flags set in prior cycles;
//   a start is never serviced in its capture cycle). Arbitration: data beats insn (see CONFIGURATION).
//  DATA: drive avl_read or avl_write + address/be/wdata; hold stable while waitrequest=1.
//   On waitrequest=0: latch readdata if read, pulse data_ready next cycle, clear flag, -> IDLE.
//  INSN: beat counter k=0..INSN_WORDS-1; avl_address={insn_addr,k}, avl_read=1, be=4'hF.
//   Each waitrequest=0 latches avl_readdata into slot k, k++; after last beat pulse insn_ready next cycle,
//   clear flag, -> IDLE. A fetch is never interrupted by a data request; beats go out back-to-back.
//  Min latency: start at cycle 0 -> command cycle 1 -> ready cycle 2 (zero wait); fetch adds 1 cycle/beat.
//  Ready pulses registered; insn_ready and data_ready never assert in the same cycle.
//  avl_read and avl_write never both 1; both 0 in IDLE. Address wrap: {insn_addr,k} never carries out.
//  Reset mid-transfer: immediate abort, strobes drop asynchronously, no ready pulse, pending data lost.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: when both pending in IDLE, grant port that did NOT win last grant
//   (last-grant bit resets to "insn", so first contention goes to data). Undefined: fixed data priority.
// TESTING
//  Single data read, wait=0, mem[0x100]=0xDEADBEEF: data_start@0 addr=0x100 -> avl_read@1, data_ready@2, rd=0xDEADBEEF
//  Write be=4'b0101 wr=0x11223344 addr=0x20, waitrequest=1 for 3 cycles -> cmd stable 4 cycles, one data_ready, no read
//  Fetch INSN_WORDS=2 insn_addr=0x8, mem[0x10]=0xA, mem[0x11]=0xB -> avl reads 0x10,0x11; insn_data_rd=64'hB_0000000A
//  Both start same cycle, no macro -> data serviced first, then fetch; with macro 2nd contention grants insn
//  data_start during in-flight 2-beat fetch -> fetch completes first, data issued right after insn_ready
//  rst asserted while waitrequest=1 mid-fetch -> strobes 0 same cycle, no insn_ready, next request served normally

Source files
------------

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: merges the arm810 fetch port (multi-beat reads) and data port onto one 32-bit memory master.
// Latency: start in cycle 0, command in cycle 1, ready pulse in cycle 2 with zero wait; each extra fetch beat adds 1.
// Backpressure: the command is held unchanged while avl_waitrequest=1. Optional macro MEM_ARB_ROUND_ROBIN_EN.
module core_mem_arbiter #(
  parameter int INSN_WORDS = 2,
  localparam int IW = $clog2(INSN_WORDS),
  localparam int KW = (IW == 0) ? 1 : IW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    insn_start,
  input  logic [29-IW:0]          insn_addr,
  output logic                    insn_ready,
  output logic [32*INSN_WORDS-1:0] insn_data_rd,
  input  logic                    data_start,
  input  logic [29:0]             data_addr,
  input  logic                    data_write,
  input  logic [3:0]              data_data_be,
  input  logic [31:0]             data_data_wr,
  output logic                    data_ready,
  output logic [31:0]             data_data_rd,
  output logic [29:0]             avl_address,
  output logic                    avl_read,
  output logic                    avl_write,
  output logic [31:0]             avl_writedata,
  output logic [3:0]              avl_byteenable,
  input  logic [31:0]             avl_readdata,
  input  logic                    avl_waitrequest
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_INSN} state_t;

  state_t state_q;
  logic   data_pend_q;
  logic   insn_pend_q;

  // Latched data request
  logic [29:0] d_addr_q;
  logic        d_write_q;
  logic [3:0]  d_be_q;
  logic [31:0] d_wr_q;

  // Latched fetch request and beat sequencing
  logic [29-IW:0]                i_addr_q;
  logic [KW-1:0]                 beat_q;
  logic [INSN_WORDS-1:0][31:0]   ibuf_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = data port won the most recent contended grant; resets to "insn" so data wins first contention
  logic last_data_q;
`endif

  logic                        data_take, insn_take;
  logic                        data_req, insn_req, grant_data;
  logic [29:0]                 d_addr_d;
  logic                        d_write_d;
  logic [3:0]                  d_be_d;
  logic [31:0]                 d_wr_d;
  logic [29-IW:0]              i_addr_d;
  logic [29:0]                 i_base_d, i_base_q;
  logic [KW-1:0]               beat_nxt;
  logic                        beat_last;
  logic [INSN_WORDS-1:0][31:0] ibuf_d;

  // Request view for this cycle: a fresh start is visible to arbitration so the command issues next cycle.
  always_comb begin
    data_take = data_start & ~data_pend_q;
    insn_take = insn_start & ~insn_pend_q;
    data_req  = data_pend_q | data_take;
    insn_req  = insn_pend_q | insn_take;
    d_addr_d  = data_take ? data_addr    : d_addr_q;
    d_write_d = data_take ? data_write   : d_write_q;
    d_be_d    = data_take ? data_data_be : d_be_q;
    d_wr_d    = data_take ? data_data_wr : d_wr_q;
    i_addr_d  = insn_take ? insn_addr    : i_addr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_data = data_req & (~insn_req | ~last_data_q);
`else
    grant_data = data_req;
`endif
    // Fetch addresses are {insn_addr, beat}; the low IW bits are always zero in the base
    i_base_d  = 30'(i_addr_d) << IW;
    i_base_q  = 30'(i_addr_q) << IW;
    beat_nxt  = beat_q + 1'b1;
    beat_last = (beat_q == KW'(INSN_WORDS - 1));
    ibuf_d    = ibuf_q;
    ibuf_d[beat_q] = avl_readdata;
  end

  // Request capture, arbitration FSM and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      data_pend_q    <= 1'b0;
      insn_pend_q    <= 1'b0;
      d_addr_q       <= '0;
      d_write_q      <= 1'b0;
      d_be_q         <= '0;
      d_wr_q         <= '0;
      i_addr_q       <= '0;
      beat_q         <= '0;
      ibuf_q         <= '0;
      avl_address    <= '0;
      avl_read       <= 1'b0;
      avl_write      <= 1'b0;
      avl_writedata  <= '0;
      avl_byteenable <= '0;
      insn_ready     <= 1'b0;
      insn_data_rd   <= '0;
      data_ready     <= 1'b0;
      data_data_rd   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data_q    <= 1'b0;
`endif
    end else begin
      insn_ready <= 1'b0;
      data_ready <= 1'b0;

      if (data_take) begin
        data_pend_q <= 1'b1;
        d_addr_q    <= data_addr;
        d_write_q   <= data_write;
        d_be_q      <= data_data_be;
        d_wr_q      <= data_data_wr;
      end
      if (insn_take) begin
        insn_pend_q <= 1'b1;
        i_addr_q    <= insn_addr;
      end

      case (state_q)
        S_IDLE: begin
          if (grant_data) begin
            state_q        <= S_DATA;
            avl_address    <= d_addr_d;
            avl_read       <= ~d_write_d;
            avl_write      <= d_write_d;
            avl_byteenable <= d_be_d;
            avl_writedata  <= d_wr_d;
          end else if (insn_req) begin
            state_q        <= S_INSN;
            beat_q         <= '0;
            avl_address    <= i_base_d;
            avl_read       <= 1'b1;
            avl_write      <= 1'b0;
            avl_byteenable <= 4'hF;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          // Only contended grants move the fairness pointer
          if (data_req && insn_req) last_data_q <= grant_data;
`endif
        end
        S_DATA: begin
          if (!avl_waitrequest) begin
            if (!d_write_q) data_data_rd <= avl_readdata;
            data_ready  <= 1'b1;
            data_pend_q <= 1'b0;
            avl_read    <= 1'b0;
            avl_write   <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_INSN: begin
          // Beats go out back-to-back; a data request waits for the whole fetch
          if (!avl_waitrequest) begin
            ibuf_q <= ibuf_d;
            if (beat_last) begin
              insn_data_rd <= ibuf_d;
              insn_ready   <= 1'b1;
              insn_pend_q  <= 1'b0;
              avl_read     <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              beat_q      <= beat_nxt;
              avl_address <= i_base_q | 30'(beat_nxt);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Core must not restart a port that still has a request outstanding.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(data_start && data_pend_q)) else $error("data_start while data request outstanding");
      assert (!(insn_start && insn_pend_q)) else $error("insn_start while fetch outstanding");
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios then random traffic against a word-level memory model.
// Memory responder drives waitrequest/readdata on the falling edge; checks sample on the falling edge.
// Expected results come from a reference memory updated at request time (one data access outstanding).
module tb_core_mem_arbiter;
  localparam int NW  = 2;
  localparam int IWB = $clog2(NW);
  localparam int IAW = 30 - IWB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              insn_start = 1'b0;
  logic [IAW-1:0]    insn_addr = '0;
  logic              insn_ready;
  logic [32*NW-1:0]  insn_data_rd;
  logic              data_start = 1'b0;
  logic [29:0]       data_addr = '0;
  logic              data_write = 1'b0;
  logic [3:0]        data_data_be = '0;
  logic [31:0]       data_data_wr = '0;
  logic              data_ready;
  logic [31:0]       data_data_rd;
  logic [29:0]       avl_address;
  logic              avl_read, avl_write;
  logic [31:0]       avl_writedata;
  logic [3:0]        avl_byteenable;
  logic [31:0]       avl_readdata = '0;
  logic              avl_waitrequest = 1'b0;

  core_mem_arbiter #(.INSN_WORDS(NW)) dut (
    .clk(clk), .rst(rst),
    .insn_start(insn_start), .insn_addr(insn_addr), .insn_ready(insn_ready), .insn_data_rd(insn_data_rd),
    .data_start(data_start), .data_addr(data_addr), .data_write(data_write), .data_data_be(data_data_be),
    .data_data_wr(data_data_wr), .data_ready(data_ready), .data_data_rd(data_data_rd),
    .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write), .avl_writedata(avl_writedata),
    .avl_byteenable(avl_byteenable), .avl_readdata(avl_readdata), .avl_waitrequest(avl_waitrequest)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Physical memory behind the responder, and the reference view of it
  logic [31:0] pmem [0:1023];
  logic [31:0] rmem [0:1023];

  // Reference model state
  bit              data_busy = 0, d_exp_w = 0, d_wr_seen = 0;
  logic [29:0]     d_exp_a;
  logic [3:0]      d_exp_be;
  logic [31:0]     d_exp_wr, d_exp_rd;
  bit              insn_busy = 0;
  logic [32*NW-1:0] i_exp;
  logic [31:0]     held_drd = '0;
  logic [32*NW-1:0] held_ird = '0;
  int              wait_pct = 0;
  int              wait_hold = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wr, input logic [3:0] be);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wr[8*b +: 8];
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_data(input bit w, input logic [29:0] a, input logic [3:0] be, input logic [31:0] wr);
    data_start = 1'b1; data_write = w; data_addr = a; data_data_be = be; data_data_wr = wr;
    data_busy = 1; d_wr_seen = 0; d_exp_w = w; d_exp_a = a; d_exp_be = be; d_exp_wr = wr;
    if (w) rmem[a[9:0]] = merge(rmem[a[9:0]], wr, be);
    else   d_exp_rd = rmem[a[9:0]];
  endtask

  task automatic start_insn(input int a);
    insn_start = 1'b1; insn_addr = IAW'(a);
    insn_busy = 1;
    for (int k = 0; k < NW; k++) i_exp[32*k +: 32] = rmem[10'(a*NW + k)];
  endtask

  // Clock until both ports have completed; reports which ready pulse came first (1=data, 2=insn)
  task automatic run_until_idle(output int first);
    first = 0;
    for (int i = 0; i < 300 && (data_busy || insn_busy); i++) begin
      tick();
      data_start = 1'b0;
      insn_start = 1'b0;
      if (first == 0) begin
        if (data_ready) first = 1;
        else if (insn_ready) first = 2;
      end
    end
    chk("idle_timeout", 128'({data_busy, insn_busy}), 128'(0));
  endtask

  // Falling-edge monitor and memory responder
  initial begin
    logic [67:0] cmd, prev_cmd;
    bit prev_hold;
    bit w;
    prev_hold = 0;
    prev_cmd  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_drd = '0; held_ird = '0; prev_hold = 0; wait_hold = 0;
        avl_waitrequest = 1'b0;
      end else begin
        cmd = {avl_address, avl_read, avl_write, avl_byteenable, avl_writedata};
        if (prev_hold) chk("cmd_stable", 128'(cmd), 128'(prev_cmd));
        if (avl_read || avl_write) chk("rw_exclusive", 128'(avl_read & avl_write), 128'(0));
        if (data_ready || insn_ready) chk("ready_exclusive", 128'(data_ready & insn_ready), 128'(0));

        if (data_ready) begin
          chk("data_ready_expected", 128'(data_busy), 128'(1));
          if (data_busy && d_exp_w) chk("write_was_issued", 128'(d_wr_seen), 128'(1));
          if (data_busy && !d_exp_w) held_drd = d_exp_rd;
          chk("data_rd", 128'(data_data_rd), 128'(held_drd));
          data_busy = 0;
        end else begin
          chk("data_rd_held", 128'(data_data_rd), 128'(held_drd));
        end

        if (insn_ready) begin
          chk("insn_ready_expected", 128'(insn_busy), 128'(1));
          if (insn_busy) held_ird = i_exp;
          chk("insn_rd", 128'(insn_data_rd), 128'(held_ird));
          insn_busy = 0;
        end else begin
          chk("insn_rd_held", 128'(insn_data_rd), 128'(held_ird));
        end

        w = 0;
        if (avl_read || avl_write) begin
          if (wait_hold > 0) begin w = 1; wait_hold--; end
          else w = ($urandom_range(0, 99) < 32'(wait_pct));
        end
        avl_waitrequest = w;
        avl_readdata = avl_read ? pmem[avl_address[9:0]] : $urandom;
        if (avl_write && !w) begin
          chk("write_legal", 128'(data_busy && d_exp_w && !d_wr_seen), 128'(1));
          chk("write_addr", 128'(avl_address), 128'(d_exp_a));
          chk("write_be", 128'(avl_byteenable), 128'(d_exp_be));
          chk("write_data", 128'(avl_writedata), 128'(d_exp_wr));
          pmem[avl_address[9:0]] = merge(pmem[avl_address[9:0]], avl_writedata, avl_byteenable);
          d_wr_seen = 1;
        end
        prev_hold = (avl_read || avl_write) && w;
        prev_cmd  = cmd;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int wcnt, rcnt;
    bit got_i, saw_d;
    for (int i = 0; i < 1024; i++) begin
      pmem[i] = $urandom;
      rmem[i] = pmem[i];
    end
    pmem[32'h100] = 32'hDEADBEEF; rmem[32'h100] = 32'hDEADBEEF;
    pmem[32'h20]  = 32'hAABBCCDD; rmem[32'h20]  = 32'hAABBCCDD;
    pmem[32'h10]  = 32'h0000000A; rmem[32'h10]  = 32'h0000000A;
    pmem[32'h11]  = 32'h0000000B; rmem[32'h11]  = 32'h0000000B;

    // Reset state
    tick(); tick();
    chk("rst_avl_read", 128'(avl_read), 128'(0));
    chk("rst_avl_write", 128'(avl_write), 128'(0));
    chk("rst_avl_addr", 128'(avl_address), 128'(0));
    chk("rst_readies", 128'({insn_ready, data_ready}), 128'(0));
    chk("rst_insn_rd", 128'(insn_data_rd), 128'(0));
    chk("rst_data_rd", 128'(data_data_rd), 128'(0));
    rst = 1'b0;
    tick();

    // Single zero-wait data read: command in cycle 1, ready in cycle 2
    start_data(0, 30'h100, 4'hF, 32'h0);
    tick(); data_start = 1'b0;
    chk("t1_cmd_read", 128'({avl_read, avl_write}), 128'(2'b10));
    chk("t1_cmd_addr", 128'(avl_address), 128'(30'h100));
    chk("t1_no_early_ready", 128'(data_ready), 128'(0));
    tick();
    chk("t1_ready", 128'(data_ready), 128'(1));
    chk("t1_rdata", 128'(data_data_rd), 128'(32'hDEADBEEF));
    tick();

    // Write held under 3 wait cycles: 4 command cycles, no read strobe
    wait_hold = 3;
    start_data(1, 30'h20, 4'b0101, 32'h11223344);
    tick(); data_start = 1'b0;
    wcnt = 0; rcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (avl_write) wcnt++;
      if (avl_read) rcnt++;
      if (data_ready) break;
      tick();
    end
    chk("t2_write_cycles", 128'(wcnt), 128'(4));
    chk("t2_no_read", 128'(rcnt), 128'(0));
    tick();
    chk("t2_mem", 128'(pmem[32'h20]), 128'(32'hAA22CC44));

    // Two-beat fetch from fetch address 0x8
    start_insn(8);
    run_until_idle(first);
    chk("t3_insn_data", 128'(insn_data_rd), 128'(64'h0000000B_0000000A));

    // Contention: first goes to data in both modes, second depends on arbitration mode
    start_data(0, 30'h100, 4'hF, 32'h0);
    start_insn(9);
    run_until_idle(first);
    chk("t4_first_contention", 128'(first), 128'(1));
    start_data(0, 30'h101, 4'hF, 32'h0);
    start_insn(10);
    run_until_idle(first);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("t4_second_contention", 128'(first), 128'(2));
`else
    chk("t4_second_contention", 128'(first), 128'(1));
`endif

    // Data request during an in-flight fetch issues right after insn_ready
    start_insn(16);
    tick(); insn_start = 1'b0;
    start_data(0, 30'h155, 4'hF, 32'h0);
    tick(); data_start = 1'b0;
    got_i = 0; saw_d = 0;
    for (int i = 0; i < 30; i++) begin
      if (data_ready) saw_d = 1;
      if (insn_ready) begin
        got_i = 1;
        tick();
        chk("t5_data_cmd", 128'({avl_read, avl_address}), 128'({1'b1, 30'h155}));
        break;
      end
      tick();
    end
    chk("t5_fetch_first", 128'({got_i, saw_d}), 128'(2'b10));
    run_until_idle(first);

    // Reset while a fetch beat is stalled
    wait_hold = 1000;
    start_insn(32);
    tick(); insn_start = 1'b0;
    tick();
    chk("t6_fetch_active", 128'(avl_read), 128'(1));
    rst = 1'b1;
    #1;
    chk("t6_strobe_drop", 128'({avl_read, avl_write}), 128'(0));
    chk("t6_no_ready", 128'(insn_ready), 128'(0));
    insn_busy = 0;
    wait_hold = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_quiet", 128'({insn_ready, data_ready, avl_read, avl_write}), 128'(0));
    end
    start_data(0, 30'h100, 4'hF, 32'h0);
    run_until_idle(first);
    chk("t6_after_reset_rd", 128'(data_data_rd), 128'(32'hDEADBEEF));

    // Random traffic with random wait states
    wait_pct = 35;
    for (int c = 0; c < 3000; c++) begin
      data_start = 1'b0;
      insn_start = 1'b0;
      if (!data_busy && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1)
          start_data(1, 30'(32'h200 + $urandom_range(0, 511)), 4'($urandom), $urandom);
        else
          start_data(0, 30'($urandom_range(0, 1023)), 4'hF, $urandom);
      end
      if (!insn_busy && $urandom_range(0, 3) == 0) start_insn(int'($urandom_range(0, 255)));
      tick();
    end
    data_start = 1'b0;
    insn_start = 1'b0;
    run_until_idle(first);

    for (int i = 512; i < 1024; i++) chk("mem_final", 128'(pmem[i]), 128'(rmem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
